// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - handshake and counter signals between the AES round sequencer and its environment
interface aes_round_ctrl_if #(
  parameter int RND_BITS = 4
);
  logic                start;
  logic                abort;
  logic                key_ready;
  logic [RND_BITS-1:0] cnt_val;
  logic                cnt_roll;
  logic                cnt_clear;
  logic                cnt_en;
  logic                load_state;
  logic                round_en;
  logic                skip_mix;
  logic                busy;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  start, abort, key_ready, cnt_val, cnt_roll, out_ready,
    output cnt_clear, cnt_en, load_state, round_en, skip_mix, busy, out_valid
  );

  modport master (
    output start, abort, key_ready, cnt_val, cnt_roll, out_ready,
    input  cnt_clear, cnt_en, load_state, round_en, skip_mix, busy, out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer driving the round counter and state register strobes
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_BITS   = 4,
  parameter int ROUND_LAT  = 1
) (
  input logic clk,
  input logic n_rst,
  aes_round_ctrl_if.slave bus
);
  localparam int WAIT_BITS = (ROUND_LAT > 2) ? $clog2(ROUND_LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, WAIT, OUT} state_t;

  state_t               state, state_nxt;
  logic [WAIT_BITS-1:0] wait_cnt, wait_nxt;
  logic                 last_rnd, last_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      last_rnd <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      last_rnd <= last_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_nxt       = wait_cnt;
    last_nxt       = last_rnd;
    bus.cnt_clear  = 1'b0;
    bus.cnt_en     = 1'b0;
    bus.load_state = 1'b0;
    bus.round_en   = 1'b0;
    bus.skip_mix   = 1'b0;
    bus.out_valid  = (state == OUT);
    bus.busy       = (state == LOAD) || (state == ROUND) || (state == WAIT);

    if (bus.abort) begin
      state_nxt     = IDLE;
      bus.cnt_clear = 1'b1;
      wait_nxt      = '0;
      last_nxt      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.cnt_clear = 1'b1;
          if (bus.start) state_nxt = LOAD;
        end
        // cnt_roll is deliberately not consulted here: a mis-cleared counter must not end the block early
        LOAD: begin
          if (bus.key_ready) begin
            bus.load_state = 1'b1;
            bus.cnt_en     = 1'b1;
            last_nxt       = 1'b0;
            state_nxt      = ROUND;
          end
        end
        ROUND: begin
          if (bus.key_ready) begin
            bus.round_en = 1'b1;
            bus.skip_mix = bus.cnt_roll;
            bus.cnt_en   = !bus.cnt_roll;
            last_nxt     = bus.cnt_roll;
            if (ROUND_LAT > 1) begin
              state_nxt = WAIT;
              wait_nxt  = WAIT_BITS'(ROUND_LAT - 2);
            end else begin
              state_nxt = bus.cnt_roll ? OUT : ROUND;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state_nxt = last_rnd ? OUT : ROUND;
          end else begin
            wait_nxt = wait_cnt - 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.cnt_clear = 1'b1;
            state_nxt     = bus.start ? LOAD : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl at ROUND_LAT 1 and 3
module tb_aes_round_ctrl;
  localparam int N  = 2000;
  localparam int NR = 10;
  localparam int EV_LOAD  = 0;
  localparam int EV_ROUND = 1;
  localparam int EV_RISE  = 2;
  localparam int EV_HS    = 3;

  typedef struct {
    int kind;
    int cyc;
    int val;
    int skip;
  } ev_t;

  logic clk = 1'b1;
  logic n_rst;
  logic start_s, abort_s, ka_s, or_s, force_s;
  bit   stim_ready = 1'b0;
  int   total = 0;
  int   bad = 0;

  bit st_a[N];
  bit ka_a[N];
  bit or_a[N];
  bit ab_a[N];
  bit fr_a[N];

  always #5 clk = ~clk;

  function automatic int next_ka(input int from);
    for (int c = from; c < N; c++) if (ka_a[c]) return c;
    return N;
  endfunction

  function automatic int first_abort(input int lo, input int hi);
    for (int c = lo; c <= hi && c < N; c++) if (ab_a[c]) return c;
    return -1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    aes_round_ctrl_if #(.RND_BITS(4)) bus ();
    logic [3:0] cnt;
    logic [6:0] ov;
    ev_t exp_q[$];
    int  exp_en;
    int  first_out;

    assign bus.start     = start_s;
    assign bus.abort     = abort_s;
    assign bus.key_ready = ka_s;
    assign bus.out_ready = or_s;
    assign bus.cnt_val   = cnt;
    assign bus.cnt_roll  = (cnt == 4'(NR)) || (force_s && cnt == 4'd0);
    assign ov = {bus.cnt_clear, bus.cnt_en, bus.load_state, bus.round_en,
                 bus.skip_mix, bus.busy, bus.out_valid};

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)             cnt <= 4'd0;
      else if (bus.cnt_clear) cnt <= 4'd0;
      else if (bus.cnt_en)    cnt <= cnt + 4'd1;
    end

    aes_round_ctrl #(.NUM_ROUNDS(NR), .RND_BITS(4), .ROUND_LAT(LAT)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus.slave)
    );

    task automatic push(input int kind, input int cyc, input int val, input int skip);
      ev_t e;
      e.kind = kind; e.cyc = cyc; e.val = val; e.skip = skip;
      exp_q.push_back(e);
    endtask

    task automatic chk(input int kind, input int cyc, input int val, input int skip);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL lat%0d unexpected_event: got kind=%0d cyc=%0d, required none", LAT, kind, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.val != val || e.skip != skip) begin
          bad++;
          $display("FAIL lat%0d event: got kind=%0d cyc=%0d val=%0d skip=%0d, required kind=%0d cyc=%0d val=%0d skip=%0d",
                   LAT, kind, cyc, val, skip, e.kind, e.cyc, e.val, e.skip);
        end
      end
    endtask

    // Event-level reference: each step waits for the first cycle with key_ready, aborts cut a block short
    initial begin : model
      int pos, t, e, a, from, earliest, o, h, st;
      wait (stim_ready);
      exp_en = 0; first_out = -1; pos = 0;
      while (1) begin
        t = pos;
        while (t < N && !(st_a[t] && !ab_a[t])) t++;
        if (t >= N) break;
        from = t + 1; earliest = t + 1; st = 0;
        for (int k = 0; k <= NR; k++) begin
          e = next_ka(earliest);
          a = first_abort(from, e);
          if (a >= 0) begin pos = a + 1; st = 1; break; end
          if (e >= N) begin st = 2; break; end
          push((k == 0) ? EV_LOAD : EV_ROUND, e, k, (k == NR) ? 1 : 0);
          if (k < NR) exp_en++;
          from = e + 1;
          earliest = (k == 0) ? e + 1 : e + LAT;
        end
        if (st == 2) break;
        if (st == 1) continue;
        o = earliest;
        a = first_abort(from, o - 1);
        if (a >= 0) begin pos = a + 1; continue; end
        if (o >= N) break;
        push(EV_RISE, o, 0, 0);
        if (first_out < 0) first_out = o;
        h = o;
        while (h < N && !or_a[h]) h++;
        a = first_abort(o, h);
        if (a >= 0) begin pos = a + 1; continue; end
        if (h >= N) break;
        push(EV_HS, h, 0, 0);
        pos = h;
      end
    end

    initial begin : monitor
      bit prev_ov;
      int en_cnt;
      wait (stim_ready);
      prev_ov = 1'b0; en_cnt = 0;
      for (int c = 0; c < N; c++) begin
        @(negedge clk);
        if (bus.cnt_en) en_cnt++;
        if (bus.load_state) chk(EV_LOAD, c, int'(bus.cnt_val), int'(bus.skip_mix));
        if (bus.round_en)   chk(EV_ROUND, c, int'(bus.cnt_val), int'(bus.skip_mix));
        if (bus.out_valid && !prev_ov) chk(EV_RISE, c, 0, 0);
        if (bus.out_valid && bus.out_ready && !bus.abort) begin
          total++;
          if (!bus.cnt_clear) begin
            bad++;
            $display("FAIL lat%0d hs_clear@%0d: got cnt_clear=0, required 1", LAT, c);
          end
          chk(EV_HS, c, 0, 0);
        end
        total++;
        if (bus.skip_mix && !bus.round_en) begin
          bad++;
          $display("FAIL lat%0d skip_gate@%0d: got skip_mix=1 round_en=0, required skip_mix=0", LAT, c);
        end
        if (ab_a[c]) begin
          total++;
          if (!bus.cnt_clear || bus.cnt_en) begin
            bad++;
            $display("FAIL lat%0d abort_strobes@%0d: got clear=%0b en=%0b, required clear=1 en=0",
                     LAT, c, bus.cnt_clear, bus.cnt_en);
          end
        end
        prev_ov = bus.out_valid;
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL lat%0d missing_events: got %0d left over, required 0", LAT, exp_q.size());
      end
      total++;
      if (en_cnt != exp_en) begin
        bad++;
        $display("FAIL lat%0d cnt_en_total: got %0d, required %0d", LAT, en_cnt, exp_en);
      end
      total++;
      if (first_out != ((g == 0) ? 12 : 32)) begin
        bad++;
        $display("FAIL lat%0d first_out_cycle: got %0d, required %0d", LAT, first_out, (g == 0) ? 12 : 32);
      end
    end
  end

  task automatic chk_vec(input string name, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic drive(input int c);
    start_s = st_a[c]; abort_s = ab_a[c]; ka_s = ka_a[c]; or_s = or_a[c]; force_s = fr_a[c];
  endtask

  initial begin
    n_rst = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (c <= 40) begin
        st_a[c] = (c == 0) || (c == 17) || (c == 34);
        ka_a[c] = 1'b1;
        or_a[c] = (c >= 17);
        ab_a[c] = (c == 40);
        fr_a[c] = 1'b0;
      end else begin
        st_a[c] = ($urandom_range(0, 99) < 15);
        ka_a[c] = ($urandom_range(0, 99) < 80);
        or_a[c] = ($urandom_range(0, 99) < 50);
        ab_a[c] = ($urandom_range(0, 99) < 1);
        fr_a[c] = ($urandom_range(0, 99) < 30);
      end
    end
    stim_ready = 1'b1;
    drive(0);
    #1;
    chk_vec("reset_lat1", g_inst[0].ov, 7'b1000000);
    chk_vec("reset_lat3", g_inst[1].ov, 7'b1000000);
    #2 n_rst = 1'b1;
    for (int c = 1; c < N; c++) begin
      @(posedge clk); #1;
      drive(c);
    end
    @(posedge clk); #1;
    start_s = 1'b0; abort_s = 1'b1; ka_s = 1'b1; or_s = 1'b0; force_s = 1'b0;
    @(posedge clk); #1;
    abort_s = 1'b0; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_s = 1'b1;
    chk_vec("wait_strobes_lat3", g_inst[1].ov, 7'b0000010);
    #2 n_rst = 1'b0;
    #1;
    chk_vec("async_reset_lat1", g_inst[0].ov, 7'b1000000);
    chk_vec("async_reset_lat3", g_inst[1].ov, 7'b1000000);
    start_s = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk_vec("idle_after_reset_lat3", g_inst[1].ov, 7'b1000000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the AES-128 encryption datapath. It consumes the round number and rollover flag produced by the round counter, and drives that counter's clear and enable inputs. It also issues load and round-update strobes to the state register and handles the start and output handshakes with the surrounding engine.

## Interface
Parameters:
- NUM_ROUNDS, 10, number of cipher rounds after the initial AddRoundKey.
- RND_BITS, 4, width of the round count.
- ROUND_LAT, 1, cycles the round datapath needs per round (≥1).

Ports:
- clk  in  1  clock; reset n_rst, asynchronous, active-low.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  request to encrypt the block presented upstream; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority after reset.
- key_ready  in  1  key schedule has the round key for index cnt_val valid.
- cnt_val  in  RND_BITS  round count from counter.
- cnt_roll  in  1  counter rollover flag; high when cnt_val == NUM_ROUNDS.
- cnt_clear  out  1  clears the counter to 0 on the next edge.
- cnt_en  out  1  increments the counter on the next edge.
- load_state  out  1  state register captures plaintext XOR key[0].
- round_en  out  1  state register captures the round result.
- skip_mix  out  1  final round; MixColumns is bypassed (valid with round_en).
- busy  out  1  high in LOAD, ROUND, WAIT.
- out_valid  out  1  ciphertext in state register is valid.
- out_ready  in  1  downstream accepts the ciphertext.

## Operation
- FSM states: IDLE, LOAD, ROUND, WAIT, OUT. Outputs are combinational decodes of the state and inputs. The state and the wait counter are registered.
- IDLE: cnt_clear=1.
  - If start=1, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: cnt_val is 0.
  - If key_ready=1, assert load_state=1 and cnt_en=1, then go to ROUND.
  - Otherwise hold in LOAD with both strobes at 0.
- ROUND: if key_ready=0, stall with all strobes at 0. If key_ready=1, assert round_en=1 and set skip_mix=cnt_roll.
  - If cnt_roll=0, also assert cnt_en=1.
  - If cnt_roll=1, keep cnt_en=0, because the counter must not advance past NUM_ROUNDS.
  - Next state, ROUND_LAT=1: ROUND if cnt_roll=0, otherwise OUT.
  - Next state, ROUND_LAT>1: WAIT, with the wait counter loaded to ROUND_LAT-2.
- WAIT: strobes are 0.
  - The wait counter decrements each cycle.
  - When it reaches 0, go to ROUND, or to OUT if the round just issued was final. A registered last-round bit records this.
- OUT: out_valid=1, held until out_ready=1.
  - On a handshake, assert cnt_clear=1.
  - If start=1 in the same cycle, go straight to LOAD (back-to-back); otherwise go to IDLE.
- abort=1 in any state:
  - Next state is IDLE and cnt_clear=1.
  - load_state, round_en and cnt_en are forced to 0 in that cycle.
  - out_valid drops on the next cycle.
- start outside IDLE and OUT is ignored. It is not queued.
- The counter contract is: clear to 0, increment by 1, with cnt_roll high when the count is at NUM_ROUNDS.
  - If cnt_roll is already high in LOAD (a mis-cleared counter), it is ignored.
  - The rounds are then driven purely by cnt_roll in ROUND.
- The wait counter is ceil(log2(ROUND_LAT)) bits wide, with a minimum of 1 bit.

## Timing
- Reset values: state IDLE, cnt_clear=1, every other output 0, wait counter 0, last-round bit 0.
- Take cycle 0 as the edge at which start is sampled in IDLE, with key_ready held at 1:
  - LOAD occurs in cycle 1.
  - round_en pulses at cycles 2, 2+ROUND_LAT, …, 2+(NUM_ROUNDS-1)·ROUND_LAT.
  - out_valid first goes high at cycle 2+NUM_ROUNDS·ROUND_LAT. This is cycle 12 for the defaults.
- Each cycle of key_ready=0 in LOAD or ROUND adds exactly one cycle of latency.
- skip_mix is high only for the single round_en pulse at which cnt_val == NUM_ROUNDS.
- Back-to-back operation: an OUT handshake with start=1 gives LOAD on the next cycle, with cnt_val=0 because of the clear.
- Reset mid-operation takes effect immediately and asynchronously, returning all outputs to their reset values.

## Test plan
- Default parameters, key_ready=1, start pulse at cycle 0 -> load_state at cycle 1, round_en at cycles 2..11, skip_mix only at cycle 11, 10 cnt_en pulses total, out_valid at cycle 12.
- ROUND_LAT=3 -> round_en at cycles 2, 5, …, 29; out_valid at cycle 32; strobes 0 in WAIT.
- key_ready dropped for 2 cycles before round 4 -> round 4 and all later events are delayed by 2 cycles; no extra cnt_en pulses.
- out_ready held at 0 for 5 cycles, then 1 with start=1 -> out_valid held for 6 cycles; cnt_clear in the handshake cycle; LOAD on the next cycle with cnt_val=0.
- abort during round 5 -> IDLE on the next cycle, cnt_clear=1, no out_valid; a new start then gives a full 10-round sequence.
- n_rst asserted during WAIT -> all outputs go to reset values asynchronously; start ignored while busy; cnt_roll forced high in LOAD -> the sequence still starts normally.
